// File: rtl/flopcmp_pkg.sv
// Shared types and constants for the flop-equivalence stimulus sequencer.
package flopcmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RISE   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_FALL   = 3'd5,
    ST_FINISH = 3'd6
  } flopcmp_state_e;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
  // An all-zero LFSR would lock up, so a zero seed is replaced by this value.
  localparam logic [31:0] SEED_ZERO_SUB = 32'h1;

  // One Galois LFSR step: shift right, fold the taps in when bit 0 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/flopcmp_sequencer_if.sv
// Control, stimulus and result signals between the sequencer and its environment.
interface flopcmp_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [31:0]       seed;
  logic [CNT_W-1:0]  num_vectors;
  logic [DATA_W-1:0] stim_data;
  logic              stim_en;
  logic              dut_clk;
  logic              all_ok;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  fail_count;
  logic              first_fail_valid;
  logic [CNT_W-1:0]  first_fail_idx;

  // Sequencer side.
  modport master (
    input  start, seed, num_vectors, all_ok,
    output stim_data, stim_en, dut_clk, busy, done,
           fail_count, first_fail_valid, first_fail_idx
  );

  // Environment side: random sources, DUT pairs and the run controller.
  modport slave (
    output start, seed, num_vectors, all_ok,
    input  stim_data, stim_en, dut_clk, busy, done,
           fail_count, first_fail_valid, first_fail_idx
  );
endinterface

// File: rtl/flopcmp_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and zero-seed substitution.
module flopcmp_lfsr32
  import flopcmp_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] q
);

  // Load has priority over step; a zero seed is swapped for the lock-up-free value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= SEED_ZERO_SUB;
    end else if (load) begin
      q <= (load_val == 32'h0) ? SEED_ZERO_SUB : load_val;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/flopcmp_sequencer.sv
// Stimulus/compare controller: launches random data, waits for it to settle,
// then pulses a private DUT clock and tallies the equivalence flag per vector.
module flopcmp_sequencer
  import flopcmp_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 2,
  parameter int HOLD_CYC   = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  flopcmp_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_LAUNCH = ST_LAUNCH;
  localparam logic [2:0] S_SETTLE = ST_SETTLE;
  localparam logic [2:0] S_RISE   = ST_RISE;
  localparam logic [2:0] S_SAMPLE = ST_SAMPLE;
  localparam logic [2:0] S_FALL   = ST_FALL;
  localparam logic [2:0] S_FINISH = ST_FINISH;

  localparam int DLY_MAX = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam logic [DLY_W-1:0] SETTLE_LOAD = DLY_W'(SETTLE_CYC - 1);
  localparam logic [DLY_W-1:0] HOLD_LOAD   = DLY_W'(HOLD_CYC - 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [DLY_W-1:0]  dly_cnt;
  logic [DLY_W-1:0]  dly_load;
  logic              dly_done;
  logic [CNT_W-1:0]  vec_idx;
  logic [CNT_W-1:0]  num_q;
  logic              last_vec;
  logic              start_go;
  logic [31:0]       lfsr_q;
  logic [31:0]       lfsr_nxt;

  logic [DATA_W-1:0] stim_data_q;
  logic              stim_en_q;
  logic              dut_clk_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W-1:0]  fail_count_q;
  logic              ffv_q;
  logic [CNT_W-1:0]  ffi_q;

  assign dly_done = (dly_cnt == '0);
  assign start_go = (state == S_IDLE) && bus.start;
  assign last_vec = ((vec_idx + CNT_W'(1)) == num_q);
  assign lfsr_nxt = lfsr_next(lfsr_q);

  flopcmp_lfsr32 u_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (start_go && (bus.num_vectors != '0)),
    .load_val (bus.seed),
    .step     (state == S_LAUNCH),
    .q        (lfsr_q)
  );

  // Next-state decode and the delay value to load on entry to each state.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
    state_nxt = state;
    dly_load  = '0;
    unique case (state)
      S_IDLE:   if (bus.start) state_nxt = (bus.num_vectors == '0) ? S_FINISH : S_LAUNCH;
      S_LAUNCH: state_nxt = S_SETTLE;
      S_SETTLE: if (dly_done) state_nxt = S_RISE;
      S_RISE:   if (dly_done) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = S_FALL;
      S_FALL:   if (dly_done) state_nxt = last_vec ? S_FINISH : S_LAUNCH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    case (state_nxt)
      S_SETTLE:     dly_load = SETTLE_LOAD;
      S_RISE, S_FALL: dly_load = HOLD_LOAD;
      default:      dly_load = '0;
    endcase
  end

  // State register and delay counter; the counter reloads whenever the state changes.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state   <= S_IDLE;
      dly_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        dly_cnt <= dly_load;
      end else if (!dly_done) begin
        dly_cnt <= dly_cnt - DLY_W'(1);
      end
    end
  end

  // Stimulus, DUT clock, status flags and the per-run result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stim_data_q  <= '0;
      stim_en_q    <= 1'b0;
      dut_clk_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_count_q <= '0;
      ffv_q        <= 1'b0;
      ffi_q        <= '0;
      vec_idx      <= '0;
      num_q        <= '0;
    end else begin
      // The DUT clock is high exactly in RISE and SAMPLE, straight from this flop.
      dut_clk_q <= (state_nxt == S_RISE) || (state_nxt == S_SAMPLE);
      busy_q    <= (state_nxt != S_IDLE) && (state_nxt != S_FINISH);
      done_q    <= (state_nxt == S_FINISH);

      if (start_go) begin
        num_q        <= bus.num_vectors;
        vec_idx      <= '0;
        fail_count_q <= '0;
        ffv_q        <= 1'b0;
        ffi_q        <= '0;
      end

      // New data lands on the edge leaving LAUNCH, well clear of any dut_clk edge.
      if (state == S_LAUNCH) begin
        stim_data_q <= lfsr_nxt[DATA_W-1:0];
        stim_en_q   <= lfsr_nxt[31];
      end

      // Anything but a clean 1 (0 or X in simulation) takes the failure branch.
      if (state == S_SAMPLE) begin
        if (bus.all_ok == 1'b1) begin
          fail_count_q <= fail_count_q;
        end else begin
          if (fail_count_q != '1) fail_count_q <= fail_count_q + CNT_W'(1);
          if (!ffv_q) begin
            ffv_q <= 1'b1;
            ffi_q <= vec_idx;
          end
        end
      end

      if ((state == S_FALL) && dly_done) begin
        vec_idx <= vec_idx + CNT_W'(1);
      end
    end
  end

  assign bus.stim_data        = stim_data_q;
  assign bus.stim_en          = stim_en_q;
  assign bus.dut_clk          = dut_clk_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.fail_count       = fail_count_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_flopcmp_sequencer.sv
// Self-checking bench for flopcmp_sequencer: random seeds and pass/fail plans
// against a queue-based reference of the expected stimulus and result tally.
module tb_flopcmp_sequencer;

  localparam int DATA_W     = 4;
  localparam int CNT_W      = 16;
  localparam int SETTLE_CYC = 2;
  localparam int HOLD_CYC   = 2;
  localparam int VEC_CYC    = 1 + SETTLE_CYC + HOLD_CYC + 1 + HOLD_CYC;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  flopcmp_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  flopcmp_sequencer #(
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W),
    .SETTLE_CYC (SETTLE_CYC),
    .HOLD_CYC   (HOLD_CYC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference LFSR step written from the polynomial definition.
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  // Per-vector all_ok plan, monitor bookkeeping.
  logic              plan [0:63];
  logic [DATA_W:0]   got_stim [$];
  int                cyc         = 0;
  int                rise_cnt    = 0;
  int                done_pulses = 0;
  int                last_change = -100;
  int                last_fall   = -100;
  logic              prev_dclk   = 1'b0;
  logic [DATA_W:0]   prev_stim   = '0;

  // Watches stimulus vs dut_clk spacing, records stimulus at each rise, drives all_ok.
  always @(negedge clk) begin
    logic [DATA_W:0] cur;
    cyc++;
    cur = {bus.stim_en, bus.stim_data};
    if (reset_n) begin
      if (cur != prev_stim) begin
        check("stim_gap_after_fall", 32'(cyc - last_fall >= HOLD_CYC), 32'd1);
        check("stim_not_on_edge", 32'(bus.dut_clk == prev_dclk), 32'd1);
        last_change = cyc;
      end
      if (bus.dut_clk && !prev_dclk) begin
        check("settle_before_rise", 32'(cyc - last_change >= SETTLE_CYC), 32'd1);
        got_stim.push_back(cur);
        if (rise_cnt < 64) bus.all_ok = plan[rise_cnt];
        rise_cnt++;
      end
      if (!bus.dut_clk && prev_dclk) last_fall = cyc;
      if (bus.done) done_pulses++;
    end
    prev_dclk = bus.dut_clk;
    prev_stim = cur;
  end

  task automatic clear_plan();
    for (int k = 0; k < 64; k++) plan[k] = 1'b1;
    bus.all_ok = 1'b1;
  endtask

  task automatic run(input logic [31:0] seed, input int n, input bit mid_start, input string name);
    int          c;
    logic [31:0] s;
    logic [DATA_W:0] exp_stim;
    int          exp_fail;
    int          exp_idx;
    bit          exp_valid;
    rise_cnt = 0;
    got_stim.delete();
    bus.seed        = seed;
    bus.num_vectors = CNT_W'(n);
    bus.start       = 1'b1;
    @(negedge clk);
    c = 1;
    while (!bus.done && c < 2000) begin
      if (mid_start && c == 20) begin
        bus.start       = 1'b1;
        bus.num_vectors = CNT_W'(1);
        bus.seed        = 32'hdead_beef;
      end else begin
        bus.start       = 1'b0;
        bus.num_vectors = CNT_W'(n);
        bus.seed        = seed;
      end
      @(negedge clk);
      c++;
    end
    check({name, ":done_latency"}, 32'(c), 32'(1 + VEC_CYC * n));
    // Start during FINISH must be ignored when mid_start is set.
    bus.start       = mid_start;
    bus.num_vectors = CNT_W'(1);
    @(negedge clk);
    bus.start = 1'b0;
    check({name, ":done_single"}, 32'(bus.done), 32'd0);
    check({name, ":busy_after"}, 32'(bus.busy), 32'd0);

    s = (seed == 32'h0) ? 32'h1 : seed;
    exp_fail  = 0;
    exp_idx   = 0;
    exp_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      s = ref_step(s);
      exp_stim = {s[31], s[DATA_W-1:0]};
      if (k < got_stim.size())
        check($sformatf("%s:stim%0d", name, k), 32'(got_stim[k]), 32'(exp_stim));
      if (plan[k] !== 1'b1) begin
        if (!exp_valid) begin
          exp_valid = 1'b1;
          exp_idx   = k;
        end
        exp_fail++;
      end
    end
    check({name, ":rises"}, 32'(rise_cnt), 32'(n));
    check({name, ":fail_count"}, 32'(bus.fail_count), 32'(exp_fail));
    check({name, ":ff_valid"}, 32'(bus.first_fail_valid), 32'(exp_valid));
    check({name, ":ff_idx"}, 32'(bus.first_fail_idx), 32'(exp_idx));
    clear_plan();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, ":stim_data"}, 32'(bus.stim_data), 32'd0);
    check({name, ":stim_en"}, 32'(bus.stim_en), 32'd0);
    check({name, ":dut_clk"}, 32'(bus.dut_clk), 32'd0);
    check({name, ":busy"}, 32'(bus.busy), 32'd0);
    check({name, ":done"}, 32'(bus.done), 32'd0);
    check({name, ":fail_count"}, 32'(bus.fail_count), 32'd0);
    check({name, ":ff_valid"}, 32'(bus.first_fail_valid), 32'd0);
    check({name, ":ff_idx"}, 32'(bus.first_fail_idx), 32'd0);
  endtask

  task automatic reset_mid_run();
    int c;
    int dp;
    rise_cnt = 0;
    got_stim.delete();
    bus.seed        = 32'h1;
    bus.num_vectors = CNT_W'(5);
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c = 0;
    while (rise_cnt < 2 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("rst:reached_rise2", 32'(rise_cnt), 32'd2);
    check("rst:dut_clk_high", 32'(bus.dut_clk), 32'd1);
    #1 reset_n = 1'b0;
    #1 check_outputs_zero("rst_async");
    dp = done_pulses;
    repeat (4) @(negedge clk);
    check("rst:dut_clk_held", 32'(bus.dut_clk), 32'd0);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rst:no_done", 32'(done_pulses), 32'(dp));
    check("rst:dut_clk_idle", 32'(bus.dut_clk), 32'd0);
    check("rst:busy_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.seed        = 32'h0;
    bus.num_vectors = '0;
    clear_plan();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run(32'h1, 3, 1'b0, "race3");
    run($urandom, 10, 1'b0, "pass10");

    plan[3] = 1'b0;
    plan[6] = 1'b0;
    run($urandom, 8, 1'b0, "miss8");

    plan[0] = 1'bx;
    run($urandom, 2, 1'b0, "x_ok");

    run($urandom, 0, 1'b0, "zero");
    run(32'h0, 4, 1'b0, "seed0");
    run($urandom, 6, 1'b1, "busy_start");

    reset_mid_run();

    for (int r = 0; r < 5; r++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) plan[k] = ($urandom_range(0, 3) != 0);
      run($urandom, n, r[0], $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
